// File: rtl/blackjack_pkg.sv
// Shared constants and the deck controller state encoding for the blackjack deck path.
// Card values are 7 bits wide and the deck RAM is addressed with 6 bits.
package blackjack_pkg;

    localparam int          DECK_SIZE = 52;
    localparam int          CARD_W    = 7;
    localparam int          ADDR_W    = 6;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [3:0] {
        LOAD,
        SH_PICK,
        SH_RD_I,
        SH_RD_J,
        SH_CAP_J,
        SH_WR_I,
        SH_WR_J,
        READY,
        DEAL_RD,
        DEAL_OUT
    } deck_state_e;

endpackage

// File: rtl/deck_ctrl_if.sv
// Bundle of the loader write port, the single deck RAM port and the dealer handshake.
// The slave modport is the controller's view; master is the surrounding system's view.
interface deck_ctrl_if;
    import blackjack_pkg::*;

    logic              load_done;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_wen;
    logic [CARD_W-1:0] ld_data;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wen;
    logic [CARD_W-1:0] ram_wdata;
    logic [CARD_W-1:0] ram_rdata;

    logic              shuffle_req;
    logic              deal_req;
    logic              deal_valid;
    logic [CARD_W-1:0] deal_card;
    logic              ready;
    logic              deck_empty;

    modport slave (
        input  load_done, ld_addr, ld_wen, ld_data, ram_rdata, shuffle_req, deal_req,
        output ram_addr, ram_wen, ram_wdata, deal_valid, deal_card, ready, deck_empty
    );

    modport master (
        output load_done, ld_addr, ld_wen, ld_data, ram_rdata, shuffle_req, deal_req,
        input  ram_addr, ram_wen, ram_wdata, deal_valid, deal_card, ready, deck_empty
    );

endinterface

// File: rtl/deck_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1) that steps every cycle.
// A zero seed would lock the register at zero, so SEED must be non-zero.
module lfsr16
    import blackjack_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic        feedback;

    assign feedback = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEED;
        end else begin
            state_q <= {state_q[14:0], feedback};
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/deck_ctrl.sv
// Deck controller: passes the loader through to the deck RAM, Fisher-Yates shuffles it in place
// with LFSR rejection sampling, then deals cards in address order on request.
module deck_ctrl
    import blackjack_pkg::*;
#(
    parameter int          DECK_SIZE = blackjack_pkg::DECK_SIZE,
    parameter logic [15:0] LFSR_SEED = blackjack_pkg::LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst,
    deck_ctrl_if.slave bus
);

    localparam int                PTR_W    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DECK_SIZE - 1);
    localparam logic [PTR_W-1:0]  PTR_FULL = PTR_W'(DECK_SIZE);

    deck_state_e       state_q;
    logic [ADDR_W-1:0] i_q;
    logic [ADDR_W-1:0] j_q;
    logic [CARD_W-1:0] tmp_i_q;
    logic [CARD_W-1:0] tmp_j_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_wen_q;
    logic              deal_valid_q;
    logic [CARD_W-1:0] deal_card_q;
    logic              ready_q;

    logic [15:0]       lfsr;
    logic [ADDR_W-1:0] pick;
    logic              lfsr_unused;
    logic              deck_empty;
    logic              load_pass;
    logic [CARD_W-1:0] fsm_wdata;

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .state_o(lfsr)
    );

    // Only the low bits index the deck; the rest of the LFSR state just keeps the sequence long.
    assign pick        = lfsr[ADDR_W-1:0];
    assign lfsr_unused = ^lfsr[15:ADDR_W];

    assign deck_empty = (ptr_q == PTR_FULL);
    assign load_pass  = (state_q == LOAD);
    assign fsm_wdata  = (state_q == SH_WR_J) ? tmp_i_q : tmp_j_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= LOAD;
            i_q          <= '0;
            j_q          <= '0;
            tmp_i_q      <= '0;
            tmp_j_q      <= '0;
            ptr_q        <= '0;
            ram_addr_q   <= '0;
            ram_wen_q    <= 1'b0;
            deal_valid_q <= 1'b0;
            deal_card_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state
            // and the defaults below are simply overridden where a pulse is wanted.
            deal_valid_q <= 1'b0;
            ram_wen_q    <= 1'b0;

            unique case (state_q)
                LOAD: begin
                    if (bus.load_done) begin
                        i_q     <= LAST_IDX;
                        state_q <= SH_PICK;
                    end
                end

                SH_PICK: begin
                    // Out-of-range draws are rejected rather than folded, keeping j uniform.
                    if (pick <= i_q) begin
                        j_q        <= pick;
                        ram_addr_q <= i_q;
                        state_q    <= SH_RD_I;
                    end
                end

                SH_RD_I: begin
                    ram_addr_q <= j_q;
                    state_q    <= SH_RD_J;
                end

                SH_RD_J: begin
                    tmp_i_q <= bus.ram_rdata;
                    state_q <= SH_CAP_J;
                end

                SH_CAP_J: begin
                    tmp_j_q    <= bus.ram_rdata;
                    ram_addr_q <= i_q;
                    ram_wen_q  <= 1'b1;
                    state_q    <= SH_WR_I;
                end

                SH_WR_I: begin
                    ram_addr_q <= j_q;
                    ram_wen_q  <= 1'b1;
                    state_q    <= SH_WR_J;
                end

                SH_WR_J: begin
                    i_q <= i_q - 1'b1;
                    if (i_q == ADDR_W'(1)) begin
                        ptr_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= READY;
                    end else begin
                        state_q <= SH_PICK;
                    end
                end

                READY: begin
                    if (bus.shuffle_req) begin
                        i_q     <= LAST_IDX;
                        ready_q <= 1'b0;
                        state_q <= SH_PICK;
                    end else if (bus.deal_req && !deck_empty) begin
                        ram_addr_q <= ptr_q[ADDR_W-1:0];
                        ready_q    <= 1'b0;
                        state_q    <= DEAL_RD;
                    end
                end

                DEAL_RD: begin
                    state_q <= DEAL_OUT;
                end

                DEAL_OUT: begin
                    deal_card_q  <= bus.ram_rdata;
                    deal_valid_q <= 1'b1;
                    ptr_q        <= ptr_q + 1'b1;
                    ready_q      <= 1'b1;
                    state_q      <= READY;
                end

                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    // While loading, the loader owns the RAM port outright.
    assign bus.ram_addr   = load_pass ? bus.ld_addr : ram_addr_q;
    assign bus.ram_wen    = load_pass ? bus.ld_wen  : ram_wen_q;
    assign bus.ram_wdata  = load_pass ? bus.ld_data : fsm_wdata;

    assign bus.deal_valid = deal_valid_q;
    assign bus.deal_card  = deal_card_q;
    assign bus.ready      = ready_q;
    assign bus.deck_empty = deck_empty;

endmodule
